fx_square_seq: RTL and testbench
================================

Name: fx_square_seq

Overview:
- Iterative fixed-point squarer: y = a·a in signed Q(QINT).(QFRAC) format, with saturation. It is the inverse operation of the pipeline's square-root block.
- Used on the variance/path-statistics side of the QMC-LSM datapath to square values such as volatility terms and regression residuals.
- Also used by self-checking benches to confirm that square-root outputs round-trip back to their inputs.
- Area-lean: a shift-add multiplier retires one multiplier bit per cycle. Valid/ready handshakes on both sides.

Parameters:
- WIDTH, fpga_cfg_pkg::FP_WIDTH, total fixed-point word width in bits, sign included.
- QINT, fpga_cfg_pkg::FP_QINT, integer bits, sign bit included.
- QFRAC (localparam) = WIDTH-QINT, number of fractional bits.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand valid
- in_ready  out  1  block can accept an operand
- a  in  WIDTH  signed operand, two's complement
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- sq_out  out  WIDTH  squared result, always non-negative
- ovf  out  1  result saturated; qualified by out_valid

Behaviour:
- Reset values: in_ready=1, out_valid=0, sq_out=0, ovf=0, state=IDLE. All internal registers clear.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at a rising edge: latch mag=|a| as a WIDTH-bit unsigned value (0x80..0 maps to 2^(WIDTH-1)).
  - Copy mag into a multiplier shift register. Clear the 2·WIDTH-bit accumulator and the bit counter. Go to CALC.
- CALC:
  - in_ready=0.
  - Each cycle: if multiplier bit 0 is 1, add (mag << cnt) to the accumulator. Then shift the multiplier right by 1 and increment cnt.
  - Exactly WIDTH cycles, with no early exit. Zero operands also take WIDTH cycles.
  - On the cycle with cnt==WIDTH-1, register the result and go to DONE.
- Result rule:
  - p = acc >> QFRAC (truncation, no rounding).
  - If p > 2^(WIDTH-1)-1: sq_out = 2^(WIDTH-1)-1 and ovf=1.
  - Otherwise: sq_out = p[WIDTH-1:0] and ovf=0.
- DONE:
  - out_valid=1. sq_out and ovf are held stable until out_valid&&out_ready.
  - On that handshake: out_valid drops on the next edge and the FSM returns to IDLE.
  - in_ready stays 0 in DONE. There is no overlap with a new operand.
- Latency and throughput:
  - Operand accepted at edge k; out_valid is high after edge k+WIDTH.
  - With out_ready tied high: one result per WIDTH+2 cycles.
- Input is ignored unless in_ready=1. Changes on a or in_valid during CALC/DONE have no effect.
- out_ready is ignored while out_valid=0.
- Reset mid-operation (any state): the block immediately returns to reset values and the in-flight operand is discarded. No stale out_valid may appear after rst_n deasserts.
- sq_out retains its last value in IDLE/CALC but is only meaningful while out_valid=1.
- No X propagation: the accumulator is fully defined from acceptance onward.

Test Plan:
Bench configuration: WIDTH=32, QINT=16 (Q16.16). Expected out_valid is 32 edges after acceptance.
- Basic squares, out_ready=1:
  - a=0x00018000 (1.5) -> sq_out=0x00024000 (2.25), ovf=0.
  - a=0x00010000 (1.0) -> sq_out=0x00010000.
  - a=0x00000000 -> sq_out=0x00000000, still after 32 cycles.
- Negative and min-magnitude:
  - a=0xFFFE0000 (-2.0) -> 0x00040000 (4.0), ovf=0.
  - a=0x00000001 (2^-16) -> 0x00000000, truncated, ovf=0.
- Saturation:
  - a=0x01000000 (256.0) -> sq_out=0x7FFFFFFF, ovf=1.
  - a=0x80000000 (-32768.0) -> sq_out=0x7FFFFFFF, ovf=1.
  - a=0x00B50000 (181.0) -> 0x7FF90000 (32761.0), ovf=0. This is the boundary case just below saturation.
- Backpressure:
  - Hold out_ready=0 for 6 cycles after out_valid rises. sq_out, ovf and out_valid must be stable and in_ready=0 throughout.
  - Toggle a and in_valid during this window; the next result must be unaffected.
- Back-to-back with out_ready=1 and in_valid held high over operands 3.0, -0.5, 10.0:
  - Results 0x00090000, 0x00004000, 0x00640000, in order.
  - Accept-to-accept spacing of exactly 34 cycles.
- Reset mid-CALC:
  - Assert rst_n=0 at cycle 10 of CALC. All outputs go to reset values asynchronously.
  - After release: no out_valid pulse. A new operand 2.0 yields 0x00040000.

Source files
------------

// File: rtl/fx_square_seq.sv
// Iterative signed fixed-point squarer with saturation.
// Shift-add core retires one multiplier bit per cycle.
package fpga_cfg_pkg;
  localparam int FP_WIDTH = 32;
  localparam int FP_QINT  = 16;
endpackage

module fx_square_seq
  import fpga_cfg_pkg::*;
#(
  parameter int WIDTH = FP_WIDTH,
  parameter int QINT  = FP_QINT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sq_out,
  output logic             ovf
);

  localparam int QFRAC = WIDTH - QINT;
  localparam int CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int PW    = 2 * WIDTH;

  localparam logic [PW-1:0] MAXP =
    {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MAXO =
    {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] mag;
  logic [WIDTH-1:0] mplr;
  logic [PW-1:0]    acc;
  logic [CW-1:0]    cnt;

  logic             accept;
  logic             release_out;
  logic             last;
  logic [WIDTH-1:0] mag_in;
  logic [PW-1:0]    addend;
  logic [PW-1:0]    acc_nxt;
  logic [PW-1:0]    p;
  logic             sat;

  assign in_ready    = (state == IDLE);
  assign out_valid   = (state == DONE);
  assign accept      = in_valid && in_ready;
  assign release_out = out_valid && out_ready;
  assign last        = (cnt == LAST);

  // 0x80..0 negates to itself, read unsigned as 2^(WIDTH-1).
  assign mag_in = a[WIDTH-1] ? (~a + WIDTH'(1)) : a;

  assign addend  = mplr[0]
                 ? ({{WIDTH{1'b0}}, mag} << cnt)
                 : '0;
  assign acc_nxt = acc + addend;
  assign p       = acc_nxt >> QFRAC;
  assign sat     = (p > MAXP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept)      state_nxt = CALC;
      CALC: if (last)        state_nxt = DONE;
      DONE: if (release_out) state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag    <= '0;
      mplr   <= '0;
      acc    <= '0;
      cnt    <= '0;
      sq_out <= '0;
      ovf    <= 1'b0;
    end else begin
      unique case (1'b1)
        (state == IDLE): begin
          if (accept) begin
            mag  <= mag_in;
            mplr <= mag_in;
            acc  <= '0;
            cnt  <= '0;
          end
        end
        (state == CALC): begin
          acc  <= acc_nxt;
          mplr <= mplr >> 1;
          cnt  <= cnt + CW'(1);
          if (last) begin
            sq_out <= sat ? MAXO : p[WIDTH-1:0];
            ovf    <= sat;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fx_square_seq.sv
// Directed bench for fx_square_seq in Q16.16.
// Covers latency, saturation, backpressure, streaming, reset.
module tb_fx_square_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sq_out;
  logic        ovf;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit mon_en = 0;
  int acc_cyc[$];
  logic [31:0] res_q[$];

  fx_square_seq #(
    .WIDTH(32),
    .QINT (16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sq_out   (sq_out),
    .ovf      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mon_en) begin
      if (in_valid && in_ready) acc_cyc.push_back(cyc);
      if (out_valid && out_ready) res_q.push_back(sq_out);
    end
  end

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input string tag,
                       input logic [31:0] op,
                       input logic [31:0] exp_sq,
                       input logic exp_ovf,
                       input int hold);
    int n;
    logic [31:0] s0;
    logic o0;
    @(negedge clk);
    check({tag, "_rdy"}, in_ready, 1'b1);
    out_ready = (hold == 0);
    in_valid  = 1'b1;
    a         = op;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = $urandom;
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_lat"}, n, 32);
    check({tag, "_sq"}, sq_out, exp_sq);
    check({tag, "_ovf"}, ovf, exp_ovf);
    s0 = sq_out;
    o0 = ovf;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = ~in_valid;
      a        = $urandom;
      @(posedge clk);
      #1;
      check({tag, "_bp"},
            {in_ready, out_valid, ovf, sq_out},
            {1'b0, 1'b1, o0, s0});
    end
    if (hold > 0) begin
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    check({tag, "_drop"}, out_valid, 1'b0);
  endtask

  task automatic wait_acc(input int k);
    int n = 0;
    while (acc_cyc.size() < k && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("b2b_acc_wait", acc_cyc.size() >= k, 1'b1);
  endtask

  initial begin
    int n;
    int pulses;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", {in_ready, out_valid, ovf, sq_out},
          {1'b1, 1'b0, 1'b0, 32'h0});
    @(negedge clk);
    rst_n = 1'b1;

    do_op("sq1p5",  32'h00018000, 32'h00024000, 1'b0, 0);
    do_op("sq1p0",  32'h00010000, 32'h00010000, 1'b0, 0);
    do_op("sq0",    32'h00000000, 32'h00000000, 1'b0, 0);
    do_op("sqm2",   32'hFFFE0000, 32'h00040000, 1'b0, 0);
    do_op("sqlsb",  32'h00000001, 32'h00000000, 1'b0, 0);
    do_op("sq256",  32'h01000000, 32'h7FFFFFFF, 1'b1, 0);
    do_op("sqmin",  32'h80000000, 32'h7FFFFFFF, 1'b1, 0);
    do_op("sq181",  32'h00B50000, 32'h7FF90000, 1'b0, 0);
    do_op("bp",     32'h00030000, 32'h00090000, 1'b0, 6);
    do_op("postbp", 32'h00020000, 32'h00040000, 1'b0, 0);

    @(negedge clk);
    mon_en    = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a         = 32'h00030000;
    wait_acc(1);
    a = 32'hFFFF8000;
    wait_acc(2);
    a = 32'h000A0000;
    wait_acc(3);
    in_valid = 1'b0;
    n = 0;
    while (res_q.size() < 3 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("b2b_cnt", res_q.size(), 3);
    if (res_q.size() >= 3 && acc_cyc.size() >= 3) begin
      check("b2b_r0", res_q[0], 32'h00090000);
      check("b2b_r1", res_q[1], 32'h00004000);
      check("b2b_r2", res_q[2], 32'h00640000);
      check("b2b_sp1", acc_cyc[1] - acc_cyc[0], 34);
      check("b2b_sp2", acc_cyc[2] - acc_cyc[1], 34);
    end
    @(negedge clk);
    mon_en = 1'b0;

    @(negedge clk);
    in_valid = 1'b1;
    a        = 32'h00050000;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid", {in_ready, out_valid, ovf, sq_out},
          {1'b1, 1'b0, 1'b0, 32'h0});
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) pulses++;
    end
    check("rst_nostale", pulses, 0);
    do_op("postrst", 32'h00020000, 32'h00040000, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
